// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder backed by a DEPTH x 32-bit register array.
//
// Ports:
//   ACLK, ARESET          : clock (rising edge) and synchronous active-high reset
//   AW*  (AWADDR/VALID/READY)        : write address channel
//   W*   (WDATA/WSTRB/VALID/READY)   : write data channel, WSTRB byte enables
//   B*   (BRESP/BVALID/BREADY)       : write response channel
//   AR*  (ARADDR/VALID/READY)        : read address channel
//   R*   (RDATA/RRESP/RVALID/RREADY) : read data channel
//
// Word index is addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
// Optional feature: define AXI_LITE_MEM_DECERR_EN to answer out-of-range word
// indices with SLVERR (write suppressed, RDATA = 0). Otherwise indices wrap.
// All handshake outputs are registered so they read 0 throughout reset.
module axi_lite_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned IdxW     = ADDR_WIDTH - 2;
  localparam int unsigned MemAw    = $clog2(DEPTH);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e              w_state_q;
  logic                  aw_held_q, w_held_q;
  logic [IdxW-1:0]       aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NumBytes-1:0]   wstrb_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;

  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_hs, w_hs, ar_hs;
  logic                  aw_have, w_have, wr_commit, wr_en;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NumBytes-1:0]   wr_strb;
  logic                  wr_err, rd_err;

  assign aw_hs   = AWVALID & awready_q;
  assign w_hs    = WVALID & wready_q;
  assign ar_hs   = ARVALID & arready_q;
  assign aw_have = aw_held_q | aw_hs;
  assign w_have  = w_held_q | w_hs;

  // Latched payload takes priority; otherwise use the payload handshaking now.
  assign wr_idx  = aw_held_q ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held_q ? wdata_q : WDATA;
  assign wr_strb = w_held_q ? wstrb_q : WSTRB;
  assign rd_idx  = ARADDR[ADDR_WIDTH-1:2];

`ifdef AXI_LITE_MEM_DECERR_EN
  assign wr_err = (wr_idx >> MemAw) != '0;
  assign rd_err = (rd_idx >> MemAw) != '0;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_commit = (w_state_q == W_IDLE) & aw_have & w_have & ~ARESET;
  assign wr_en     = wr_commit & ~wr_err;

  // Upper index bits only matter when decode errors are enabled.
  logic unused_addr;
  assign unused_addr = ^{AWADDR[1:0], ARADDR[1:0], wr_idx, rd_idx};

  // Array is deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wr_strb[b]) mem[wr_idx[MemAw-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (wr_commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_err ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end else begin
            // Also raises the readies on the first edge out of reset.
            awready_q <= ~aw_have;
            wready_q  <= ~w_have;
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              aw_idx_q  <= AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= WDATA;
              wstrb_q  <= WSTRB;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            // Reads the array before any same-edge write lands.
            rdata_q   <= rd_err ? '0 : mem[rd_idx[MemAw-1:0]];
            rresp_q   <= rd_err ? 2'b10 : 2'b00;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule
